// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch-unit types, reset PC, NOP encoding and alignment helper
package inst_fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/inst_fetch_pc_reg.sv
// inst_fetch_pc_reg: 32-bit PC register with sync reset and load enable
module inst_fetch_pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] d,
  output logic [31:0] q
);
  // PC only moves when the owner asserts ld
  always_ff @(posedge clk)
    if (rst) q <= RESET_VAL;
    else if (ld) q <= d;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding request/response fetch with valid/ready hand-off to decode (optional IFETCH_MISALIGN_CHECK_EN)
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] NPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);
  state_t state, state_d, hold_next;
  logic accept;
  logic [31:0] pc_d;
  assign accept = state == S_HOLD && inst_ready;
  assign imem_addr = PC;
  assign imem_req = state == S_REQ && !rst;
  assign inst_valid = state == S_HOLD;
  inst_fetch_pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .ld(accept),
    .d(pc_d),
    .q(PC)
  );
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign;
  assign misalign = |NPC[1:0];
  assign pc_d = NPC;
  assign hold_next = misalign ? S_FAULT : S_REQ;
  // sticky fault, cleared only by reset
  always_ff @(posedge clk)
    if (rst) fetch_fault <= 1'b0;
    else if (accept && misalign) fetch_fault <= 1'b1;
`else
  assign pc_d = word_align(NPC);
  assign hold_next = S_REQ;
  assign fetch_fault = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    if (rst) state <= S_REQ;
    else state <= state_d;
  // next state: REQ waits for gnt, WAIT for rvalid, HOLD for decode accept, FAULT is terminal
  always_comb begin
    state_d = state;
    state_d = state == S_REQ  ? (imem_gnt    ? S_WAIT    : S_REQ)
            : state == S_WAIT ? (imem_rvalid ? S_HOLD    : S_WAIT)
            : state == S_HOLD ? (inst_ready  ? hold_next : S_HOLD)
            : S_FAULT;
  end
  // instruction buffer: captured only on the response to our own request
  always_ff @(posedge clk)
    if (rst) begin
      inst <= NOP;
      inst_pc <= RESET_PC;
    end else if (state == S_WAIT && imem_rvalid) begin
      inst <= imem_rdata;
      inst_pc <= PC;
    end
endmodule
